clock12_setter: RTL and testbench

CLOCK12_SETTER -- requirements
Module: clock12_setter

---
 rtl/clock12_setter_if.sv | 36 +++
 rtl/clock12_setter.sv | 127 ++++++++++++
 tb/tb_clock12_setter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clock12_setter_if.sv
// clock12_setter_if -- button, live-time and edited-time signals of the
// 12-hour clock setter.
//   master : drives buttons and the live clock value, observes edit outputs
//   slave  : the setter itself
//   btn_mode/btn_up/btn_down/btn_cancel : raw button levels
//   cur_PM/cur_hours/cur_minutes        : live time from the running clock
//   propagate                           : one-cycle load strobe
//   out_PM/out_hours/out_minutes        : edited time
//   editing/field                       : edit status (field 1=h 2=m 3=AM/PM)
interface clock12_setter_if;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic       btn_cancel;
    logic       cur_PM;
    logic [3:0] cur_hours;
    logic [5:0] cur_minutes;
    logic       propagate;
    logic       out_PM;
    logic [3:0] out_hours;
    logic [5:0] out_minutes;
    logic       editing;
    logic [1:0] field;

    modport master (
        output btn_mode, btn_up, btn_down, btn_cancel,
        output cur_PM, cur_hours, cur_minutes,
        input  propagate, out_PM, out_hours, out_minutes, editing, field
    );

    modport slave (
        input  btn_mode, btn_up, btn_down, btn_cancel,
        input  cur_PM, cur_hours, cur_minutes,
        output propagate, out_PM, out_hours, out_minutes, editing, field
    );
endinterface

// File: rtl/clock12_setter.sv
// clock12_setter -- button-driven time editor for a 12-hour clock.
// A mode press snapshots the live time, then steps through hours, minutes
// and AM/PM; the final mode press issues a one-cycle propagate strobe that
// loads the edited time into the running clock. Cancel abandons the edit.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : clock12_setter_if.slave (buttons, live time, edit outputs)
module clock12_setter (
    input logic             clk,
    input logic             reset,
    clock12_setter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        EDIT_HOUR,
        EDIT_MIN,
        EDIT_AMPM,
        COMMIT
    } state_t;

    state_t state;

    logic prev_mode, prev_up, prev_down, prev_cancel;
    logic press_mode, press_up, press_down, press_cancel;
    logic step_up, step_down;
    logic [3:0] load_hours, hour_inc, hour_dec;
    logic [5:0] load_minutes, min_inc, min_dec;

    // One action per press: only the 0->1 transition counts.
    assign press_mode   = bus.btn_mode   & ~prev_mode;
    assign press_up     = bus.btn_up     & ~prev_up;
    assign press_down   = bus.btn_down   & ~prev_down;
    assign press_cancel = bus.btn_cancel & ~prev_cancel;

    // Simultaneous up and down presses cancel each other out.
    assign step_up   = press_up & ~press_down;
    assign step_down = press_down & ~press_up;

    // Out-of-range live values are sanitised on load.
    assign load_hours   = (bus.cur_hours == 4'd0 || bus.cur_hours > 4'd12) ? 4'd12 : bus.cur_hours;
    assign load_minutes = (bus.cur_minutes > 6'd59) ? 6'd0 : bus.cur_minutes;

    assign hour_inc = (bus.out_hours >= 4'd12) ? 4'd1  : bus.out_hours + 4'd1;
    assign hour_dec = (bus.out_hours <= 4'd1)  ? 4'd12 : bus.out_hours - 4'd1;
    assign min_inc  = (bus.out_minutes >= 6'd59) ? 6'd0  : bus.out_minutes + 6'd1;
    assign min_dec  = (bus.out_minutes == 6'd0)  ? 6'd59 : bus.out_minutes - 6'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            prev_mode       <= 1'b0;
            prev_up         <= 1'b0;
            prev_down       <= 1'b0;
            prev_cancel     <= 1'b0;
            bus.propagate   <= 1'b0;
            bus.out_PM      <= 1'b0;
            bus.out_hours   <= 4'd12;
            bus.out_minutes <= '0;
            bus.editing     <= 1'b0;
            bus.field       <= 2'd0;
        end else begin
            prev_mode   <= bus.btn_mode;
            prev_up     <= bus.btn_up;
            prev_down   <= bus.btn_down;
            prev_cancel <= bus.btn_cancel;

            case (state)
                IDLE: begin
                    if (press_mode) begin
                        bus.out_PM      <= bus.cur_PM;
                        bus.out_hours   <= load_hours;
                        bus.out_minutes <= load_minutes;
                        bus.editing     <= 1'b1;
                        bus.field       <= 2'd1;
                        state           <= EDIT_HOUR;
                    end
                end

                EDIT_HOUR, EDIT_MIN, EDIT_AMPM: begin
                    // Priority: cancel, then mode, then up/down.
                    if (press_cancel) begin
                        bus.editing <= 1'b0;
                        bus.field   <= 2'd0;
                        state       <= IDLE;
                    end else if (press_mode) begin
                        case (state)
                            EDIT_HOUR: begin
                                bus.field <= 2'd2;
                                state     <= EDIT_MIN;
                            end
                            EDIT_MIN: begin
                                bus.field <= 2'd3;
                                state     <= EDIT_AMPM;
                            end
                            default: begin
                                bus.editing   <= 1'b0;
                                bus.field     <= 2'd0;
                                bus.propagate <= 1'b1;
                                state         <= COMMIT;
                            end
                        endcase
                    end else if (step_up || step_down) begin
                        case (state)
                            EDIT_HOUR: bus.out_hours   <= step_up ? hour_inc : hour_dec;
                            EDIT_MIN:  bus.out_minutes <= step_up ? min_inc  : min_dec;
                            default:   bus.out_PM      <= ~bus.out_PM;
                        endcase
                    end
                end

                COMMIT: begin
                    bus.propagate <= 1'b0;
                    state         <= IDLE;
                end

                default: begin
                    bus.propagate <= 1'b0;
                    bus.editing   <= 1'b0;
                    bus.field     <= 2'd0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock12_setter.sv
// tb_clock12_setter -- directed scenarios plus randomized button traffic for
// clock12_setter, checked every cycle against a behavioural model of the
// edit procedure (phase number 0..4 and plain modular time arithmetic).
module tb_clock12_setter;

    logic clk;
    logic reset;
    clock12_setter_if bus ();

    clock12_setter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: phase 0 = idle, 1 = hours, 2 = minutes, 3 = AM/PM, 4 = commit.
    int m_phase;
    int m_h;
    int m_m;
    bit m_pm;
    bit m_prop;
    bit pv_mode, pv_up, pv_down, pv_cancel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_h = 12; m_m = 0; m_pm = 0; m_prop = 0;
        pv_mode = 0; pv_up = 0; pv_down = 0; pv_cancel = 0;
    endtask

    task automatic model_step();
        bit pm, pu, pd, pc;
        int d;
        pm = bus.btn_mode   && !pv_mode;
        pu = bus.btn_up     && !pv_up;
        pd = bus.btn_down   && !pv_down;
        pc = bus.btn_cancel && !pv_cancel;
        if (m_phase == 4) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (pm) begin
                m_pm = bus.cur_PM;
                m_h  = (bus.cur_hours >= 1 && bus.cur_hours <= 12) ? int'(bus.cur_hours) : 12;
                m_m  = (bus.cur_minutes <= 59) ? int'(bus.cur_minutes) : 0;
                m_phase = 1;
            end
        end else if (pc) begin
            m_phase = 0;
        end else if (pm) begin
            m_phase = m_phase + 1;
        end else if (pu != pd) begin
            d = pu ? 1 : -1;
            if (m_phase == 1) m_h = ((m_h - 1 + d + 12) % 12) + 1;
            else if (m_phase == 2) m_m = (m_m + d + 60) % 60;
            else m_pm = !m_pm;
        end
        m_prop    = (m_phase == 4);
        pv_mode   = bus.btn_mode;
        pv_up     = bus.btn_up;
        pv_down   = bus.btn_down;
        pv_cancel = bus.btn_cancel;
    endtask

    task automatic check_all(input string tag);
        bit in_edit;
        in_edit = (m_phase >= 1 && m_phase <= 3);
        check({tag, ".propagate"}, bus.propagate, m_prop);
        check({tag, ".out_PM"}, bus.out_PM, m_pm);
        check({tag, ".out_hours"}, bus.out_hours, m_h);
        check({tag, ".out_minutes"}, bus.out_minutes, m_m);
        check({tag, ".editing"}, bus.editing, in_edit);
        check({tag, ".field"}, bus.field, in_edit ? m_phase : 0);
    endtask

    task automatic tick(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(posedge clk);
            #1;
            check_all(tag);
        end
    endtask

    task automatic set_btns(input bit m, input bit u, input bit d, input bit c);
        bus.btn_mode = m; bus.btn_up = u; bus.btn_down = d; bus.btn_cancel = c;
    endtask

    // b: 0 = mode, 1 = up, 2 = down, 3 = cancel
    task automatic press(input int b, input string tag);
        set_btns(b == 0, b == 1, b == 2, b == 3);
        tick(1, tag);
        set_btns(0, 0, 0, 0);
        tick(1, tag);
    endtask

    task automatic set_cur(input bit pm, input int h, input int m);
        bus.cur_PM = pm;
        bus.cur_hours = 4'(h);
        bus.cur_minutes = 6'(m);
    endtask

    initial begin
        reset = 1'b1;
        set_btns(0, 0, 0, 0);
        set_cur(0, 12, 0);
        model_reset();
        #12;
        check_all("reset");
        reset = 1'b0;
        tick(2, "idle");

        // 11:59 AM -> edit to 1:00 PM and commit.
        set_cur(0, 11, 59);
        press(0, "s1_enter");
        check("s1_enter_hours", bus.out_hours, 11);
        press(1, "s1_up1");
        check("s1_hour_12", bus.out_hours, 12);
        press(1, "s1_up2");
        check("s1_hour_wrap", bus.out_hours, 1);
        check("s1_pm_kept", bus.out_PM, 0);
        press(0, "s1_to_min");
        press(1, "s1_min_up");
        check("s1_min_wrap", bus.out_minutes, 0);
        check("s1_no_carry", bus.out_hours, 1);
        press(0, "s1_to_ampm");
        press(1, "s1_toggle");
        set_btns(1, 0, 0, 0);
        tick(1, "s1_commit");
        check("s1_prop_hi", bus.propagate, 1);
        check("s1_out_pm", bus.out_PM, 1);
        check("s1_out_h", bus.out_hours, 1);
        check("s1_out_m", bus.out_minutes, 0);
        set_btns(0, 0, 0, 0);
        tick(1, "s1_after");
        check("s1_prop_lo", bus.propagate, 0);
        tick(2, "s1_idle");

        // 1:00 AM -> down on hours and minutes.
        set_cur(0, 1, 0);
        press(0, "s2_enter");
        press(2, "s2_hdown");
        press(0, "s2_to_min");
        press(2, "s2_mdown");
        check("s2_hours", bus.out_hours, 12);
        check("s2_minutes", bus.out_minutes, 59);
        check("s2_pm", bus.out_PM, 0);
        press(3, "s2_cancel");
        check("s2_cancel_idle", bus.editing, 0);

        // Held up gives one step; up+down together gives none.
        set_cur(1, 7, 10);
        press(0, "s3_enter");
        press(0, "s3_to_min");
        set_btns(0, 1, 0, 0);
        tick(20, "s3_hold");
        check("s3_one_step", bus.out_minutes, 11);
        set_btns(0, 0, 0, 0);
        tick(1, "s3_release");
        set_btns(0, 1, 1, 0);
        tick(1, "s3_both");
        check("s3_both_nochange", bus.out_minutes, 11);
        set_btns(0, 0, 0, 0);
        tick(1, "s3_release2");
        press(3, "s3_cancel");

        // Cancel beats up in AM/PM field.
        set_cur(0, 5, 30);
        press(0, "s4_enter");
        press(0, "s4_min");
        press(0, "s4_ampm");
        set_btns(0, 1, 0, 1);
        tick(1, "s4_cancel_up");
        check("s4_idle", bus.field, 0);
        check("s4_no_prop", bus.propagate, 0);
        check("s4_pm_kept", bus.out_PM, 0);
        set_btns(0, 0, 0, 0);
        tick(3, "s4_after");

        // Out-of-range live values.
        set_cur(1, 0, 63);
        press(0, "s6_enter");
        check("s6_hours", bus.out_hours, 12);
        check("s6_minutes", bus.out_minutes, 0);
        check("s6_field", bus.field, 1);
        press(3, "s6_cancel");

        // Async reset during COMMIT, mode held through reset release.
        set_cur(1, 3, 45);
        press(0, "s5_enter");
        press(0, "s5_min");
        press(0, "s5_ampm");
        set_btns(1, 0, 0, 0);
        tick(1, "s5_commit");
        check("s5_prop_hi", bus.propagate, 1);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("s5_reset");
        check("s5_prop_drop", bus.propagate, 0);
        check("s5_hours12", bus.out_hours, 12);
        #2;
        reset = 1'b0;
        tick(1, "s5_held_press");
        check("s5_held_enter", bus.field, 1);
        set_btns(0, 0, 0, 0);
        tick(1, "s5_release");
        press(3, "s5_cancel");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if (i % 8 == 0)
                set_cur(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 63));
            set_btns($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 99) == 0) begin
                #2;
                reset = 1'b1;
                #1;
                model_reset();
                check_all("rnd_reset");
                #1;
                reset = 1'b0;
            end
            tick(1, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
